// File: rtl/ram_copy_pkg.sv
// Shared constants for the RAM copy engine: state encoding and default widths.
package ram_copy_pkg;

    localparam int RC_DATA_WIDTH = 32;
    localparam int RC_ADDR_WIDTH = 10;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        READ  = ST_READ,
        WRITE = ST_WRITE
    } rc_state_t;

endpackage

// File: rtl/single_port_ram.sv
// Single-port RAM with one-cycle registered read; writes when en&&we, reads when en&&!we.
// Latency: read data valid the cycle after the read request.
// Backpressure: none, accepts one access per cycle.
module single_port_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= din;
            end else begin
                dout <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/ram_copy_engine.sv
// Memory-to-memory copy initiator (optional fill mode under RAM_COPY_FILL_EN) for single_port_ram.
// Latency: 2 cycles per copied word (read then write), 1 cycle per filled word; done after E(2*len) / E(len).
// Backpressure: none; start is only sampled in IDLE and ignored while busy.
module ram_copy_engine
    import ram_copy_pkg::*;
#(
    parameter int DATA_WIDTH = RC_DATA_WIDTH,
    parameter int ADDR_WIDTH = RC_ADDR_WIDTH,
    parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] src_addr,
    input  logic [ADDR_WIDTH-1:0] dst_addr,
    input  logic [LEN_WIDTH-1:0]  len,
    input  logic                  fill,
    input  logic [DATA_WIDTH-1:0] fill_data,
    output logic                  busy,
    output logic                  done,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_din,
    input  logic [DATA_WIDTH-1:0] mem_dout
);

    rc_state_t             state_q, state_d;
    logic [ADDR_WIDTH-1:0] src_q, src_d;
    logic [ADDR_WIDTH-1:0] dst_q, dst_d;
    logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  busy_d, done_d, en_d, we_d;
    logic [ADDR_WIDTH-1:0] addr_d;
    logic                  fill_q;
    logic                  fill_sel;

`ifdef RAM_COPY_FILL_EN
    logic [DATA_WIDTH-1:0] fill_data_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fill_q      <= 1'b0;
            fill_data_q <= '0;
        end else if (state_q == IDLE && start) begin
            fill_q      <= fill;
            fill_data_q <= fill_data;
        end
    end

    assign fill_sel = fill;
    assign mem_din  = (state_q == WRITE) ? (fill_q ? fill_data_q : mem_dout) : '0;
`else
    logic unused_fill;

    assign unused_fill = ^{fill, fill_data};
    assign fill_q      = 1'b0;
    assign fill_sel    = 1'b0;
    // Write data is the word the RAM registered at the end of the preceding READ.
    assign mem_din     = (state_q == WRITE) ? mem_dout : '0;
`endif

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        cnt_d   = cnt_q;
        busy_d  = busy;
        done_d  = 1'b0;
        en_d    = 1'b0;
        we_d    = 1'b0;
        addr_d  = '0;
        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    if (len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        src_d  = src_addr;
                        dst_d  = dst_addr;
                        cnt_d  = len;
                        busy_d = 1'b1;
                        en_d   = 1'b1;
                        if (fill_sel) begin
                            state_d = WRITE;
                            we_d    = 1'b1;
                            addr_d  = dst_addr;
                        end else begin
                            state_d = READ;
                            addr_d  = src_addr;
                        end
                    end
                end
            end
            READ: begin
                state_d = WRITE;
                en_d    = 1'b1;
                we_d    = 1'b1;
                addr_d  = dst_q;
            end
            WRITE: begin
                src_d = src_q + ADDR_WIDTH'(1);
                dst_d = dst_q + ADDR_WIDTH'(1);
                cnt_d = cnt_q - LEN_WIDTH'(1);
                if (cnt_q == LEN_WIDTH'(1)) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else if (fill_q) begin
                    state_d = WRITE;
                    en_d    = 1'b1;
                    we_d    = 1'b1;
                    addr_d  = dst_q + ADDR_WIDTH'(1);
                end else begin
                    state_d = READ;
                    en_d    = 1'b1;
                    addr_d  = src_q + ADDR_WIDTH'(1);
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            src_q    <= '0;
            dst_q    <= '0;
            cnt_q    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            mem_en   <= 1'b0;
            mem_we   <= 1'b0;
            mem_addr <= '0;
        end else begin
            state_q  <= state_d;
            src_q    <= src_d;
            dst_q    <= dst_d;
            cnt_q    <= cnt_d;
            busy     <= busy_d;
            done     <= done_d;
            mem_en   <= en_d;
            mem_we   <= we_d;
            mem_addr <= addr_d;
        end
    end

endmodule

// File: tb/tb_ram_copy_engine.sv
// Scoreboard bench for ram_copy_engine driving a single_port_ram responder.
module tb_ram_copy_engine;

    localparam int DW = 32;
    localparam int AW = 10;
    localparam int LW = AW + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] src_addr = '0;
    logic [AW-1:0] dst_addr = '0;
    logic [LW-1:0] len = '0;
    logic          fill = 1'b0;
    logic [DW-1:0] fill_data = '0;
    logic          busy, done, mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din, mem_dout;

    logic          tb_sel = 1'b0, tb_en = 1'b0, tb_we = 1'b0;
    logic [AW-1:0] tb_addr = '0;
    logic [DW-1:0] tb_din = '0;
    logic          ram_en, ram_we, rd_vld = 1'b0;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;

    typedef struct packed {
        logic [31:0] done_cyc;
        logic [31:0] busy_n;
        logic [31:0] rd_n;
        logic [31:0] wr_n;
    } xfer_t;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } rd_t;

    xfer_t exp_q[$];
    rd_t   rd_q[$];
    int    checks = 0, errors = 0, cyc = 0;
    int    busy_n = 0, rd_n = 0, wr_n = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) rd_vld <= tb_sel & tb_en & ~tb_we;

    assign ram_en   = tb_sel ? tb_en   : mem_en;
    assign ram_we   = tb_sel ? tb_we   : mem_we;
    assign ram_addr = tb_sel ? tb_addr : mem_addr;
    assign ram_din  = tb_sel ? tb_din  : mem_din;

    ram_copy_engine #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) u_dut (
        .clk(clk), .rst(rst), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
        .len(len), .fill(fill), .fill_data(fill_data), .busy(busy), .done(done),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
        .mem_dout(mem_dout)
    );

    single_port_ram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) u_ram (
        .clk(clk), .en(ram_en), .we(ram_we), .addr(ram_addr), .din(ram_din), .dout(mem_dout)
    );

    // Monitor: per-transfer activity counters, done timing, idle bus values, RAM readback.
    always @(negedge clk) begin
        xfer_t e;
        rd_t   r;
        if (rst) begin
            busy_n = 0; rd_n = 0; wr_n = 0;
        end else begin
            if (busy) busy_n++;
            if (mem_en && mem_we) wr_n++;
            if (mem_en && !mem_we) rd_n++;
            if (!mem_en) begin
                checks++;
                if (mem_we || mem_addr != '0) begin
                    errors++;
                    $display("FAIL idle_bus: got we=%0b addr=%0d, expected we=0 addr=0", mem_we, mem_addr);
                end
            end
            if (done) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_done: got done at cycle %0d, expected none", cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (cyc != e.done_cyc || busy_n != e.busy_n || rd_n != e.rd_n || wr_n != e.wr_n) begin
                        errors++;
                        $display("FAIL xfer: got cyc=%0d busy=%0d rd=%0d wr=%0d, expected cyc=%0d busy=%0d rd=%0d wr=%0d",
                                 cyc, busy_n, rd_n, wr_n, e.done_cyc, e.busy_n, e.rd_n, e.wr_n);
                    end
                end
                busy_n = 0; rd_n = 0; wr_n = 0;
            end
            if (rd_vld) begin
                checks++;
                if (rd_q.size() == 0) begin
                    errors++;
                    $display("FAIL mem_read: got unexpected read data %0h, expected no read", mem_dout);
                end else begin
                    r = rd_q.pop_front();
                    if (mem_dout !== r.data) begin
                        errors++;
                        $display("FAIL mem[%0d]: got %0h, expected %0h", r.addr, mem_dout, r.data);
                    end
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic ram_wr(input int a, input logic [DW-1:0] d);
        @(negedge clk);
        tb_sel = 1'b1; tb_en = 1'b1; tb_we = 1'b1; tb_addr = AW'(a); tb_din = d;
        @(negedge clk);
        tb_sel = 1'b0; tb_en = 1'b0; tb_we = 1'b0;
    endtask

    task automatic ram_rd(input int a, input logic [DW-1:0] d);
        rd_t r;
        @(negedge clk);
        tb_sel = 1'b1; tb_en = 1'b1; tb_we = 1'b0; tb_addr = AW'(a);
        r.addr = AW'(a); r.data = d;
        rd_q.push_back(r);
        @(negedge clk);
        tb_sel = 1'b0; tb_en = 1'b0;
    endtask

    // span = edges from E0 to the edge after which done is high; also the busy cycle count.
    task automatic go(input int s, input int d, input int n, input logic f,
                      input logic [DW-1:0] fd, input int span, input int rds, input int wrs);
        xfer_t e;
        @(negedge clk);
        start = 1'b1; src_addr = AW'(s); dst_addr = AW'(d); len = LW'(n);
        fill = f; fill_data = fd;
        e.done_cyc = cyc + 1 + span; e.busy_n = span; e.rd_n = rds; e.wr_n = wrs;
        exp_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_drain(input string nm);
        for (int i = 0; i < 300; i++) begin
            if (exp_q.size() == 0 && rd_q.size() == 0) break;
            @(negedge clk);
        end
        checks++;
        if (exp_q.size() != 0 || rd_q.size() != 0) begin
            errors++;
            $display("FAIL %s_timeout: got %0d pending, expected 0", nm, exp_q.size() + rd_q.size());
            exp_q.delete();
            rd_q.delete();
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_done", 64'(done), 0);
        chk("rst_en", 64'(mem_en), 0);
        chk("rst_we", 64'(mem_we), 0);
        chk("rst_addr", 64'(mem_addr), 0);
        chk("rst_din", 64'(mem_din), 0);
        rst = 1'b0;

        // Basic copy 0..3 -> 16..19, plus a start pulse while busy that must be ignored
        for (int i = 0; i < 4; i++) ram_wr(i, 32'hA000_0000 + 32'(i));
        for (int i = 16; i < 20; i++) ram_wr(i, 32'h0);
        go(0, 16, 4, 1'b0, 32'h0, 8, 4, 4);
        @(negedge clk); start = 1'b1; len = '0;
        @(negedge clk); start = 1'b0;
        wait_drain("copy4");
        for (int i = 0; i < 4; i++) ram_rd(16 + i, 32'hA000_0000 + 32'(i));
        for (int i = 0; i < 4; i++) ram_rd(i, 32'hA000_0000 + 32'(i));
        wait_drain("copy4_rd");

        // Zero length: done after E0, no RAM access, busy never counted
        go(5, 6, 0, 1'b0, 32'h0, 0, 0, 0);
        wait_drain("len0");

        // Source wraps 1022,1023,0,1; words 2,3 re-read the freshly written mem[0],mem[1]
        ram_wr(1022, 32'hB000_0000);
        ram_wr(1023, 32'hB000_0001);
        go(1022, 0, 4, 1'b0, 32'h0, 8, 4, 4);
        wait_drain("wrap");
        ram_rd(0, 32'hB000_0000);
        ram_rd(1, 32'hB000_0001);
        ram_rd(2, 32'hB000_0000);
        ram_rd(3, 32'hB000_0001);
        ram_rd(1022, 32'hB000_0000);
        ram_rd(1023, 32'hB000_0001);
        wait_drain("wrap_rd");

        // Overlap with k=1: the first word replicates forward
        ram_wr(0, 32'd5);
        ram_wr(1, 32'd6);
        go(0, 1, 4, 1'b0, 32'h0, 8, 4, 4);
        wait_drain("overlap");
        for (int i = 1; i < 5; i++) ram_rd(i, 32'd5);
        wait_drain("overlap_rd");

        // Reset after E3: word 0 written, word 1 not, no done
        for (int i = 0; i < 2; i++) ram_wr(40 + i, 32'hD000_0000 + 32'(i));
        ram_wr(50, 32'h5050_5050);
        ram_wr(51, 32'h5151_5151);
        go(40, 50, 4, 1'b0, 32'h0, 8, 4, 4);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        exp_q.delete();
        #1;
        chk("midrst_busy", 64'(busy), 0);
        chk("midrst_en", 64'(mem_en), 0);
        chk("midrst_we", 64'(mem_we), 0);
        chk("midrst_addr", 64'(mem_addr), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        ram_rd(50, 32'hD000_0000);
        ram_rd(51, 32'h5151_5151);
        wait_drain("midrst_rd");
        go(40, 50, 2, 1'b0, 32'h0, 4, 2, 2);
        wait_drain("after_rst");
        ram_rd(50, 32'hD000_0000);
        ram_rd(51, 32'hD000_0001);
        wait_drain("after_rst_rd");

        // Fill stimulus: fills with the pattern when enabled, otherwise copies from src
        for (int i = 0; i < 3; i++) ram_wr(60 + i, 32'hC000_0000 + 32'(i));
        for (int i = 8; i < 11; i++) ram_wr(i, 32'h0);
`ifdef RAM_COPY_FILL_EN
        go(60, 8, 3, 1'b1, 32'hDEAD_BEEF, 3, 0, 3);
        wait_drain("fill");
        for (int i = 8; i < 11; i++) ram_rd(i, 32'hDEAD_BEEF);
`else
        go(60, 8, 3, 1'b1, 32'hDEAD_BEEF, 6, 3, 3);
        wait_drain("fill");
        for (int i = 0; i < 3; i++) ram_rd(8 + i, 32'hC000_0000 + 32'(i));
`endif
        wait_drain("fill_rd");

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion, expected finish before 500000");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/ram_copy_engine.md
# ram_copy_engine

Memory-to-memory copy initiator driving the en/we/addr/din/dout port of the team's single-port RAM (`single_port_ram`). The engine takes a source address, destination address and word count, then moves words one at a time: a read cycle followed by a write cycle per word, honouring the RAM's one-cycle registered read latency. It sits between the DMA control registers and the local buffer RAM and reports progress through `busy` and a `done` pulse.

## Interface
- `DATA_WIDTH`, 32, RAM word width
- `ADDR_WIDTH`, 10, RAM address width (RAM depth 2^ADDR_WIDTH)
- `LEN_WIDTH`, ADDR_WIDTH+1, transfer-length width (up to a full RAM of words)

- `clk` in 1: single clock, rising edge
- `rst` in 1: asynchronous, active-high reset
- `start` in 1: start request, sampled only in IDLE
- `src_addr` in ADDR_WIDTH: first source word address
- `dst_addr` in ADDR_WIDTH: first destination word address
- `len` in LEN_WIDTH: number of words
- `fill` in 1: fill mode select, sampled with `start`
- `fill_data` in DATA_WIDTH: fill pattern, sampled with `start`
- `busy` out 1: transfer in progress
- `done` out 1: one-cycle completion pulse
- `mem_en` out 1: RAM enable
- `mem_we` out 1: RAM write enable
- `mem_addr` out ADDR_WIDTH: RAM address
- `mem_din` out DATA_WIDTH: RAM write data
- `mem_dout` in DATA_WIDTH: RAM registered read data

## Operation
- States: IDLE, READ, WRITE. All outputs except `mem_din` are registered.
- IDLE with `start`=1 and `len`≠0: latch `src_addr`, `dst_addr`, `len` into `src_q`, `dst_q`, `cnt_q`. Go to READ with `busy`=1.
- IDLE with `start`=1 and `len`=0: `done`=1 for one cycle, `busy` stays 0, no RAM access.
- READ drives `mem_en`=1, `mem_we`=0, `mem_addr`=`src_q`. Next state is WRITE.
- WRITE drives `mem_en`=1, `mem_we`=1, `mem_addr`=`dst_q`, and `mem_din`=`mem_dout` combinationally. On exit: `src_q`+1, `dst_q`+1, `cnt_q`−1.
  - If `cnt_q`=1, go to IDLE with `busy`=0 and `done`=1.
  - Otherwise go to READ.
- Addresses increment modulo 2^ADDR_WIDTH, so wrap from 2^ADDR_WIDTH−1 to 0 is silent.
- `start` while `busy` is ignored; there is no queueing.
- Copying is strictly forward, word by word. Word i is read after word i−1 is written. With overlapping ranges where `dst_addr`=`src_addr`+k (0<k<len), the source pattern replicates with period k. This is the required behaviour.
- Asserting `rst` (including mid-transfer) immediately returns to IDLE with all outputs 0. No `done` is produced. RAM contents already written stay written.
- Outside READ/WRITE (and fill writes), `mem_en`=0, `mem_we`=0, `mem_addr`=0.

## Timing
- Reset values: `busy`=0, `done`=0, `mem_en`=0, `mem_we`=0, `mem_addr`=0. `mem_din` is 0 in IDLE.
- Let E0 be the edge that samples `start`.
  - After E0: READ of word 0.
  - After E1: WRITE of word 0, using data the RAM registered at E1.
  - Each word takes 2 cycles.
- `done` is high for the single cycle after edge E(2·len). `busy` falls at that same edge.
- A new `start` may be sampled in the `done` cycle.
- `len`=0: `done` is high in the cycle after E0.

## Configuration
- `RAM_COPY_FILL_EN` defined: `fill`=1 at start skips READ.
  - The engine writes the latched `fill_data` to `dst_q`, `dst_q`+1, … with one WRITE per cycle.
  - `done` follows edge E(len).
  - `src_addr` is ignored.
- Macro undefined: the `fill` and `fill_data` ports remain but are ignored. Every transfer is a copy.

## Structure
- Shared package/header `ram_copy_pkg` holds:
  - the state encoding localparams (IDLE=0, READ=1, WRITE=2)
  - the default width constants
- No sub-module. The engine is a single FSM with address and count registers.
- The testbench instantiates `single_port_ram` (same DATA_WIDTH/ADDR_WIDTH) as the responder.

## Test plan
- Preload mem[0..3]=A0..A3, start with src=0, dst=16, len=4 → mem[16..19]=A0..A3. `done` follows E8. `busy` is high for 8 cycles. mem[0..3] are unchanged.
- len=0 → `done` in the cycle after E0. `mem_en` is never asserted. `busy` stays 0.
- src=1022, dst=0, len=4, ADDR_WIDTH=10 → source reads wrap 1022, 1023, 0, 1. Destination reads observe the already-overwritten mem[0] (forward semantics), and the check follows that.
- Overlap: mem[0..1]=5,6, src=0, dst=1, len=4 → mem[1..4]=5,5,5,5.
- `rst` pulsed after E3 of a len=4 copy → outputs 0 immediately. mem[dst] is written and mem[dst+1] is not. No `done`. A new start then completes normally.
- With `RAM_COPY_FILL_EN`: fill=1, fill_data=0xDEADBEEF, dst=8, len=3 → mem[8..10]=0xDEADBEEF. No read cycles occur. `done` follows E3.
- Without the macro, the same stimulus performs a copy from `src_addr`.
